// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: round-robin arbiter sharing one ext_mem native-bus port among N masters
module ext_mem_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [N_MASTERS-1:0]          m_ready,
  output logic                          s_valid,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W/8-1:0]           s_wstrb,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ready,
  output logic [N_MASTERS-1:0]          grant,
  output logic                          timeout_err,
  input  logic                          err_clr
);
  localparam int SW = DATA_W / 8;
  localparam int PW = $clog2(N_MASTERS);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                r_state;
  logic [PW-1:0]         r_ptr, r_gidx, w_sel;
  logic [CW-1:0]         r_cnt;
  logic [N_MASTERS-1:0]  r_grant;
  logic                  r_s_valid, r_terr;
  logic [ADDR_W-1:0]     r_addr, w_addr;
  logic [DATA_W-1:0]     r_wdata, w_wdata;
  logic [SW-1:0]         r_wstrb, w_wstrb;
  logic                  w_busy, w_to, w_done;
  int                    w_dist, w_best;

  assign w_busy      = r_state == BUSY;
  assign w_to        = (TIMEOUT != 0) && (r_cnt == C_LAST);
  assign w_done      = w_busy && (s_ready || w_to);
  assign m_ready     = w_done ? r_grant : '0;
  assign m_rdata     = (w_busy && s_ready) ? s_rdata : '0;
  assign s_valid     = r_s_valid;
  assign s_addr      = r_addr;
  assign s_wdata     = r_wdata;
  assign s_wstrb     = r_wstrb;
  assign grant       = r_grant;
  assign timeout_err = r_terr;

  // pick the requester closest to ptr in round-robin order, with its request fields
  always_comb begin
    w_sel   = '0;
    w_addr  = '0;
    w_wdata = '0;
    w_wstrb = '0;
    w_dist  = 0;
    w_best  = N_MASTERS;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_dist = (i >= int'(r_ptr)) ? i - int'(r_ptr) : i + N_MASTERS - int'(r_ptr);
      if (m_valid[i] && w_dist < w_best) begin
        w_best  = w_dist;
        w_sel   = PW'(i);
        w_addr  = m_addr[i*ADDR_W +: ADDR_W];
        w_wdata = m_wdata[i*DATA_W +: DATA_W];
        w_wstrb = m_wstrb[i*SW +: SW];
      end
    end
  end

  // arbitration FSM: latch the winner at grant, hold until slave reply or timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_s_valid <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_cnt     <= '0;
    end else if (r_state == IDLE) begin
      r_s_valid <= |m_valid;
      r_grant   <= |m_valid ? N_MASTERS'(1) << w_sel : '0;
      if (|m_valid) begin
        r_state <= BUSY;
        r_gidx  <= w_sel;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_wstrb <= w_wstrb;
        r_cnt   <= '0;
      end
    end else if (w_done) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_s_valid <= 1'b0;
      r_ptr     <= (r_gidx == PW'(N_MASTERS - 1)) ? '0 : r_gidx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // sticky timeout flag; a real slave reply in the expiry cycle suppresses it, set beats clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_terr <= 1'b0;
    else r_terr <= (w_busy && !s_ready && w_to) ? 1'b1 : err_clr ? 1'b0 : r_terr;
  end
endmodule

// File: doc/ext_mem_arbiter.md
Name: ext_mem_arbiter

Overview:
Round-robin arbiter that shares one native-bus external-memory data port between N_MASTERS requesters: the CPU data bus (index 0) and the Versat accelerator memory port (index 1). It sits between those masters and the ext_mem data-bus input. It allows one outstanding transaction at a time. The request is latched at grant, and an optional timeout recovers from a non-responding slave.

Parameters:
N_MASTERS, 2, number of requesting masters (>=2)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
TIMEOUT, 0, BUSY-cycle limit before forced completion; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
m_valid  in  N_MASTERS  per-master request valid; held until matching m_ready
m_addr  in  N_MASTERS*ADDR_W  per-master address; master i at [i*ADDR_W +: ADDR_W]
m_wdata  in  N_MASTERS*DATA_W  per-master write data
m_wstrb  in  N_MASTERS*DATA_W/8  per-master byte strobes; 0 means read
m_rdata  out  DATA_W  read data shared by all masters; valid only with m_ready
m_ready  out  N_MASTERS  per-master completion pulse, one cycle
s_valid  out  1  request to ext_mem
s_addr  out  ADDR_W  latched address
s_wdata  out  DATA_W  latched write data
s_wstrb  out  DATA_W/8  latched strobes
s_rdata  in  DATA_W  ext_mem read data
s_ready  in  1  ext_mem completion pulse
grant  out  N_MASTERS  one-hot owner of the slave port; 0 when IDLE
timeout_err  out  1  sticky timeout flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ptr=0; grant=0; s_valid=0; s_addr/s_wdata/s_wstrb=0; m_ready=0; m_rdata=0; cnt=0; timeout_err=0.
  - A transaction in flight when reset asserts is abandoned; no m_ready is issued for it.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any m_valid is high, select the first set index searching ptr, ptr+1, ..., wrapping modulo N_MASTERS.
  - On that clock edge: latch that master's addr/wdata/wstrb into s_*, set grant one-hot, cnt=0, go to BUSY.
  - With no m_valid high, stay in IDLE; outputs are unchanged, except s_valid=0 and grant=0.
- BUSY:
  - s_valid=1, driven from the latched registers; master inputs are ignored.
  - If s_ready=1:
    - Same cycle, combinationally: m_ready[g]=1 and m_rdata=s_rdata.
    - Next edge: ptr=(g+1) mod N_MASTERS, grant=0, go to IDLE.
  - Else, if TIMEOUT!=0 and cnt==TIMEOUT-1:
    - Same cycle: m_ready[g]=1, m_rdata=0.
    - Next edge: timeout_err=1, ptr advances as above, go to IDLE.
  - Else cnt increments.
- Outside completion cycles, m_ready=0 and m_rdata=0.
- Simultaneous events:
  - s_ready and timeout expiry in the same cycle: s_ready wins, no error is flagged.
  - err_clr and a new timeout in the same cycle: set wins.
- Latency: request in cycle t gives s_valid at t+1. With s_ready at t+k (k>=1), m_ready is at t+k. The earliest next grant edge is t+k+1. Minimum spacing is 2 cycles per transaction plus slave latency.
- Protocol rules:
  - A master deasserting m_valid while granted does not abort the transaction.
  - s_ready seen in IDLE is ignored.
  - Read vs write is transparent: wstrb passes through unchanged.
- ptr is a $clog2(N_MASTERS)-bit index and wraps from N_MASTERS-1 to 0.

Test Plan:
- Single read: m_valid[0]=1, addr=0x100; slave returns s_ready at BUSY cycle 3 with rdata=0xDEADBEEF -> s_valid high from t+1, s_addr=0x100, s_wstrb=0, m_ready[0] pulses 1 cycle with m_rdata=0xDEADBEEF, grant returns to 0.
- Contention: both masters request continuously after reset -> grant order 0,1,0,1; each master receives exactly one m_ready per grant; there are no back-to-back grants to the same master.
- Write latching: m_valid[1]=1, addr=0x40, wdata=0x12345678, wstrb=0xF; master changes addr to 0x80 during BUSY -> s_addr remains 0x40 and s_wdata remains 0x12345678 until completion.
- Timeout: TIMEOUT=8, slave never responds -> m_ready pulses in BUSY cycle 8 with m_rdata=0; timeout_err=1 next cycle and stays set until err_clr=1 for one cycle. Repeat with s_ready at exactly BUSY cycle 8 -> no error.
- Reset mid-transaction: rst=0 asynchronously while BUSY -> s_valid, grant and m_ready drop to 0 immediately; no m_ready for the aborted request; after release, ptr=0, so master 0 wins a simultaneous request.
- Idle noise: s_ready pulsed while IDLE with no requests -> no m_ready, state remains IDLE.
